mesh_node: RTL and testbench

//  One processing element of the 2-D pixel comparator mesh. Compares the centre

---
 rtl/mesh_node_pkg.sv | 14 +
 rtl/mesh_node_if.sv | 26 ++
 rtl/mesh_node_pix_cmp.sv | 14 +
 rtl/mesh_node.sv | 42 ++++
 tb/tb_mesh_node.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/mesh_node_pkg.sv
// Shared constants for the pixel comparator mesh: default pixel width and the
// bit position each neighbour occupies in the 4-bit comparison vector.
package mesh_node_pkg;

    localparam int PIX_W_DEF = 2;
    localparam int NBR_NUM   = 4;

    // cmp vector layout is {N, W, E, S}
    localparam int CMP_N = 3;
    localparam int CMP_W = 2;
    localparam int CMP_E = 1;
    localparam int CMP_S = 0;

endpackage

// File: rtl/mesh_node_if.sv
// Pixel neighbourhood bundle between the mesh parent and one mesh_node.
// No handshake: the parent presents pixels and polarity every cycle and the node
// answers one cycle later; there is no valid, ready or stall on this bundle.
interface mesh_node_if
    import mesh_node_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF
);
    logic [PIX_W-1:0]   pix_c;
    logic [PIX_W-1:0]   pix_n;
    logic [PIX_W-1:0]   pix_w;
    logic [PIX_W-1:0]   pix_e;
    logic [PIX_W-1:0]   pix_s;
    logic               high;
    logic [NBR_NUM-1:0] cmp;

    modport master (
        output pix_c, pix_n, pix_w, pix_e, pix_s, high,
        input  cmp
    );

    modport slave (
        input  pix_c, pix_n, pix_w, pix_e, pix_s, high,
        output cmp
    );
endinterface

// File: rtl/mesh_node_pix_cmp.sv
// One polarity-selectable unsigned comparator between the centre pixel and a
// neighbour; equal values report 1 in both polarities.
module pix_cmp
    import mesh_node_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF
) (
    input  logic [PIX_W-1:0] c,
    input  logic [PIX_W-1:0] x,
    input  logic             high,
    output logic             res
);
    assign res = high ? (c >= x) : (c <= x);
endmodule

// File: rtl/mesh_node.sv
// One mesh processing element: compares the centre pixel against its four torus
// neighbours and registers the {N,W,E,S} result vector with one cycle of latency.
module mesh_node
    import mesh_node_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    mesh_node_if.slave bus
);
    logic [PIX_W-1:0]   nbr [NBR_NUM];
    logic [NBR_NUM-1:0] cmp_d;
    logic [NBR_NUM-1:0] cmp_q;

    assign nbr[CMP_N] = bus.pix_n;
    assign nbr[CMP_W] = bus.pix_w;
    assign nbr[CMP_E] = bus.pix_e;
    assign nbr[CMP_S] = bus.pix_s;

    for (genvar i = 0; i < NBR_NUM; i++) begin : g_cmp
        pix_cmp #(
            .PIX_W (PIX_W)
        ) u_pix_cmp (
            .c    (bus.pix_c),
            .x    (nbr[i]),
            .high (bus.high),
            .res  (cmp_d[i])
        );
    end

    // Reset wins over any input in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_q <= '0;
        end else begin
            cmp_q <= cmp_d;
        end
    end

    assign bus.cmp = cmp_q;
endmodule

// File: tb/tb_mesh_node.sv
// Self-checking bench for mesh_node: directed neighbourhood cases plus a random
// stream checked against a behavioural model of the comparison rule.
module tb_mesh_node;
    import mesh_node_pkg::*;

    localparam int PIX_W   = PIX_W_DEF;
    localparam int PIX_MAX = (1 << PIX_W) - 1;

    logic clk;
    logic rst;

    int checks = 0;
    int errors = 0;

    logic [3:0] exp_q[$];
    logic [3:0] exp_v;
    logic [3:0] got_v;

    mesh_node_if #(.PIX_W(PIX_W)) bus ();

    mesh_node #(
        .PIX_W (PIX_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rst       = 1'b1;
        bus.pix_c = '0;
        bus.pix_n = '0;
        bus.pix_w = '0;
        bus.pix_e = '0;
        bus.pix_s = '0;
        bus.high  = 1'b0;
    end

    // ---------------- reference model ----------------
    // Each neighbour bit is the rule f(c,x); neighbours listed N,W,E,S map to bits 3..0.
    function automatic logic [3:0] model(input int c, input int n, input int w,
                                         input int e, input int s,
                                         input bit h, input bit r);
        int nb[4];
        logic [3:0] v;
        nb = '{n, w, e, s};
        v  = 4'b0000;
        if (!r) begin
            for (int k = 0; k < 4; k++) begin
                if (h) v[3-k] = (c >= nb[k]);
                else   v[3-k] = (c <= nb[k]);
            end
        end
        return v;
    endfunction

    // ---------------- driver ----------------
    task automatic apply(input int c, input int n, input int w, input int e,
                         input int s, input bit h, input bit r);
        bus.pix_c = PIX_W'(c);
        bus.pix_n = PIX_W'(n);
        bus.pix_w = PIX_W'(w);
        bus.pix_e = PIX_W'(e);
        bus.pix_s = PIX_W'(s);
        bus.high  = h;
        rst       = r;
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(4'b0000);
            apply($urandom_range(PIX_MAX, 0), $urandom_range(PIX_MAX, 0),
                  $urandom_range(PIX_MAX, 0), $urandom_range(PIX_MAX, 0),
                  $urandom_range(PIX_MAX, 0), 1'($urandom_range(1, 0)), 1'b1);
            got_v = bus.cmp;
            exp_v = exp_q.pop_front();
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL reset cycle %0d: cmp=%b expected=%b", i, got_v, exp_v);
            end
        end
    endtask

    task automatic test_high_mode();
        exp_q.push_back(4'b1101);
        apply(2, 1, 2, 3, 0, 1'b1, 1'b0);
        got_v = bus.cmp;
        exp_v = exp_q.pop_front();
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL high_mode: cmp=%b expected=%b", got_v, exp_v);
        end
    endtask

    task automatic test_low_mode();
        exp_q.push_back(4'b0110);
        apply(2, 1, 2, 3, 0, 1'b0, 1'b0);
        got_v = bus.cmp;
        exp_v = exp_q.pop_front();
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL low_mode: cmp=%b expected=%b", got_v, exp_v);
        end
    endtask

    task automatic test_all_equal();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(4'b1111);
            apply(3, 3, 3, 3, 3, 1'(i % 2), 1'b0);
            got_v = bus.cmp;
            exp_v = exp_q.pop_front();
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL all_equal high=%0d: cmp=%b expected=%b", i % 2, got_v, exp_v);
            end
        end
    endtask

    task automatic test_latency();
        exp_q.push_back(4'b0000);
        exp_q.push_back(4'b1111);
        apply(0, 1, 1, 1, 1, 1'b1, 1'b0);
        got_v = bus.cmp;
        exp_v = exp_q.pop_front();
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL latency_low_centre: cmp=%b expected=%b", got_v, exp_v);
        end
        apply(3, 1, 1, 1, 1, 1'b1, 1'b0);
        got_v = bus.cmp;
        exp_v = exp_q.pop_front();
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL latency_high_centre: cmp=%b expected=%b", got_v, exp_v);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] seq[5];
        bit         rs[5];
        seq = '{4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'b1111};
        rs  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(seq[i]);
            apply(2, 2, 2, 2, 2, 1'b1, rs[i]);
            got_v = bus.cmp;
            exp_v = exp_q.pop_front();
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL reset_mid step %0d: cmp=%b expected=%b", i, got_v, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        int c, n, w, e, s;
        bit h, r;
        for (int i = 0; i < 200; i++) begin
            c = $urandom_range(PIX_MAX, 0);
            n = $urandom_range(PIX_MAX, 0);
            w = $urandom_range(PIX_MAX, 0);
            e = $urandom_range(PIX_MAX, 0);
            s = $urandom_range(PIX_MAX, 0);
            h = 1'($urandom_range(1, 0));
            r = ($urandom_range(19, 0) == 0);
            exp_q.push_back(model(c, n, w, e, s, h, r));
            apply(c, n, w, e, s, h, r);
            got_v = bus.cmp;
            exp_v = exp_q.pop_front();
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL random #%0d c=%0d n=%0d w=%0d e=%0d s=%0d high=%0d rst=%0d: cmp=%b expected=%b",
                         i, c, n, w, e, s, h, r, got_v, exp_v);
            end
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        #2;
        test_reset();
        test_high_mode();
        test_low_mode();
        test_all_equal();
        test_latency();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
